// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// the op-class decode helpers used by the controller and the divider.
package mdu_ctrl_pkg;

   typedef enum logic [6:0] {
      OP_NOP   = 7'd0,
      OP_ADD   = 7'd1,
      OP_SUB   = 7'd2,
      OP_MFHI  = 7'd10,
      OP_MFLO  = 7'd11,
      OP_MTHI  = 7'd12,
      OP_MTLO  = 7'd13,
      OP_MULT  = 7'd20,
      OP_MULTU = 7'd21,
      OP_MUL   = 7'd22,
      OP_MADD  = 7'd23,
      OP_MADDU = 7'd24,
      OP_MSUB  = 7'd25,
      OP_MSUBU = 7'd26,
      OP_DIV   = 7'd27,
      OP_DIVU  = 7'd28
   } InstrType;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } MDUStateType;

   localparam int MDU_DIV_ITER        = 32;
   localparam int MDU_MUL_LAT_DEFAULT = 2;

   function automatic logic is_mdu_op(input logic [6:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU,
         OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic is_div_op(input logic [6:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [6:0] op);
      case (op)
         OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EXE-stage to MDU connection: instruction/operands in, stall and results out.
interface mdu_ctrl_if;
   logic        EXE_Valid;
   logic [6:0]  EXE_ALUOp;
   logic [31:0] EXE_RsData;
   logic [31:0] EXE_RtData;
   logic [31:0] HI_Cur;
   logic [31:0] LO_Cur;
   logic        Flush;
   logic        MDU_Busy;
   logic        MDU_Done;
   logic        MDU_HILOWr;
   logic [31:0] MDU_HI;
   logic [31:0] MDU_LO;
   logic        MDU_RFWr;
   logic [31:0] MDU_MulRes;

   modport master (
      output EXE_Valid, EXE_ALUOp, EXE_RsData, EXE_RtData, HI_Cur, LO_Cur, Flush,
      input  MDU_Busy, MDU_Done, MDU_HILOWr, MDU_HI, MDU_LO, MDU_RFWr, MDU_MulRes
   );

   modport slave (
      input  EXE_Valid, EXE_ALUOp, EXE_RsData, EXE_RtData, HI_Cur, LO_Cur, Flush,
      output MDU_Busy, MDU_Done, MDU_HILOWr, MDU_HI, MDU_LO, MDU_RFWr, MDU_MulRes
   );
endinterface

// File: rtl/mdu_ctrl_div_radix2.sv
// 32-iteration restoring divider on operand magnitudes with signed fix-up.
// The result of the final iteration is presented combinationally with done.
module div_radix2
   import mdu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   logic [31:0] rem_reg, quo_reg, dvs_reg;
   logic [5:0]  cnt_reg;
   logic        busy_reg, neg_q_reg, neg_r_reg;

   logic [31:0] a_abs, b_abs;
   logic [32:0] shifted, diff;
   logic        fits;
   logic [31:0] rem_next, quo_next;

   assign a_abs = (is_signed && dividend[31]) ? -dividend : dividend;
   assign b_abs = (is_signed && divisor[31])  ? -divisor  : divisor;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   assign shifted  = {rem_reg, quo_reg[31]};
   assign diff     = shifted - {1'b0, dvs_reg};
   assign fits     = ~diff[32];
   assign rem_next = fits ? diff[31:0] : shifted[31:0];
   assign quo_next = {quo_reg[30:0], fits};

   assign done      = busy_reg && (cnt_reg == 6'(MDU_DIV_ITER - 1));
   assign quotient  = neg_q_reg ? -quo_next : quo_next;
   assign remainder = neg_r_reg ? -rem_next : rem_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvs_reg   <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else if (abort) begin
         busy_reg <= 1'b0;
         cnt_reg  <= '0;
      end else if (start) begin
         rem_reg   <= '0;
         quo_reg   <= a_abs;
         dvs_reg   <= b_abs;
         cnt_reg   <= '0;
         busy_reg  <= 1'b1;
         neg_q_reg <= is_signed && (dividend[31] ^ divisor[31]);
         neg_r_reg <= is_signed && dividend[31];
      end else if (busy_reg) begin
         rem_reg <= rem_next;
         quo_reg <= quo_next;
         cnt_reg <= cnt_reg + 6'd1;
         if (done) begin
            busy_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// EXE-stage multiply/divide controller: accepts one MDU op, stalls while busy,
// and returns HI/LO (or the MUL GPR result) with a one-cycle Done pulse.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MDU_MUL_LAT_DEFAULT
)(
   input  logic     clk,
   input  logic     rst,
   mdu_ctrl_if.slave bus
);

   localparam logic [1:0] MUL_LAST = 2'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

   MDUStateType state_reg, state_next;
   logic [6:0]  op_reg;
   logic [1:0]  mul_cnt_reg;
   logic [31:0] hi_reg, lo_reg, mulres_reg;

   logic        start, op_signed;
   logic [63:0] ext_rs, ext_rt, product, acc, mul_res, mul_tap;
   logic [31:0] div_q, div_r;
   logic        div_done;

   assign start = bus.EXE_Valid && is_mdu_op(bus.EXE_ALUOp) &&
                  (state_reg == IDLE) && !bus.Flush;

   // Truncating the 64x64 product is exact for both extensions mod 2^64.
   assign op_signed = is_signed_op(bus.EXE_ALUOp);
   assign ext_rs    = op_signed ? {{32{bus.EXE_RsData[31]}}, bus.EXE_RsData} : {32'b0, bus.EXE_RsData};
   assign ext_rt    = op_signed ? {{32{bus.EXE_RtData[31]}}, bus.EXE_RtData} : {32'b0, bus.EXE_RtData};
   assign product   = ext_rs * ext_rt;
   assign acc       = {bus.HI_Cur, bus.LO_Cur};

   always_comb begin
      mul_res = product;
      case (bus.EXE_ALUOp)
         OP_MADD, OP_MADDU: mul_res = acc + product;
         OP_MSUB, OP_MSUBU: mul_res = acc - product;
         default:           mul_res = product;
      endcase
   end

   // The output register is the final multiply stage; earlier stages live here.
   generate
      if (MUL_LAT == 1) begin : g_mul_comb
         assign mul_tap = mul_res;
      end else begin : g_mul_pipe
         logic [63:0] pipe_reg [MUL_LAT-1];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < MUL_LAT - 1; i++) begin
                  pipe_reg[i] <= '0;
               end
            end else begin
               if (start) begin
                  pipe_reg[0] <= mul_res;
               end
               for (int i = 1; i < MUL_LAT - 1; i++) begin
                  pipe_reg[i] <= pipe_reg[i-1];
               end
            end
         end
         assign mul_tap = pipe_reg[MUL_LAT-2];
      end
   endgenerate

   div_radix2 u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (start && is_div_op(bus.EXE_ALUOp)),
      .abort     (bus.Flush),
      .is_signed (op_signed),
      .dividend  (bus.EXE_RsData),
      .divisor   (bus.EXE_RtData),
      .quotient  (div_q),
      .remainder (div_r),
      .done      (div_done)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (is_div_op(bus.EXE_ALUOp)) state_next = DIV;
               else if (MUL_LAT == 1)        state_next = DONE;
               else                          state_next = MUL;
            end
         end
         MUL:     if (mul_cnt_reg == MUL_LAST) state_next = DONE;
         DIV:     if (div_done)                state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.Flush) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         op_reg      <= '0;
         mul_cnt_reg <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         mulres_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (start) begin
            op_reg      <= bus.EXE_ALUOp;
            mul_cnt_reg <= '0;
         end else if (state_reg == MUL) begin
            mul_cnt_reg <= mul_cnt_reg + 2'd1;
         end
         // Results only land on entry to DONE, so a flushed op never writes.
         if (state_next == DONE) begin
            if (state_reg == DIV) begin
               hi_reg <= div_r;
               lo_reg <= div_q;
            end else begin
               hi_reg     <= mul_tap[63:32];
               lo_reg     <= mul_tap[31:0];
               mulres_reg <= mul_tap[31:0];
            end
         end
      end
   end

   assign bus.MDU_Busy   = start || (state_reg == MUL) || (state_reg == DIV);
   assign bus.MDU_Done   = (state_reg == DONE);
   assign bus.MDU_HILOWr = (state_reg == DONE) && (op_reg != OP_MUL);
   assign bus.MDU_RFWr   = (state_reg == DONE) && (op_reg == OP_MUL);
   assign bus.MDU_HI     = hi_reg;
   assign bus.MDU_LO     = lo_reg;
   assign bus.MDU_MulRes = mulres_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: ops are modelled at issue and checked when Done pulses.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam int TB_MUL_LAT = 2;
   localparam int DIV_LAT    = 33;

   typedef struct {
      logic [6:0]  op;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] mulres;
      logic        hilowr;
      logic        rfwr;
      int          due;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   done_count = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   mdu_ctrl_if bus ();

   mdu_ctrl #(.MUL_LAT(TB_MUL_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [6:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [31:0] hi, input logic [31:0] lo);
      exp_t   e;
      longint sa, sb, q, r;
      logic [63:0] p, acc, res;
      sa  = longint'($signed(rs));
      sb  = longint'($signed(rt));
      acc = {hi, lo};
      e.op = op;
      e.hilowr = (op != OP_MUL);
      e.rfwr   = (op == OP_MUL);
      e.due    = 0;
      e.mulres = 32'h0;
      if (op == OP_MULT || op == OP_MUL || op == OP_MADD || op == OP_MSUB) p = 64'(sa * sb);
      else p = {32'b0, rs} * {32'b0, rt};
      case (op)
         OP_MADD, OP_MADDU: res = acc + p;
         OP_MSUB, OP_MSUBU: res = acc - p;
         OP_DIVU: begin
            if (rt == 0) res = {rs, 32'hFFFF_FFFF};
            else         res = {rs % rt, rs / rt};
         end
         OP_DIV: begin
            if (rt == 0) res = {rs, (rs[31] ? 32'h1 : 32'hFFFF_FFFF)};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: res = p;
      endcase
      e.hi = res[63:32];
      e.lo = res[31:0];
      if (op == OP_MUL) e.mulres = res[31:0];
      return e;
   endfunction

   // Scoreboard consumer: every Done pulse must match the oldest issued op.
   always @(negedge clk) begin
      if (!rst && bus.MDU_Done) begin
         done_count++;
         if (sb_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL unexpected_done: Done at cyc %0d with no op outstanding", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            $display("[TB] op=%0d due=%0d cyc=%0d HILOWr=%0b RFWr=%0b HI=%08h LO=%08h MulRes=%08h",
                     mon_e.op, mon_e.due, cyc, bus.MDU_HILOWr, bus.MDU_RFWr, bus.MDU_HI, bus.MDU_LO, bus.MDU_MulRes);
            tests_run++;
            if (cyc !== mon_e.due) begin
               tests_failed++;
               $display("FAIL done_cycle op=%0d: got cyc %0d, expected %0d", mon_e.op, cyc, mon_e.due);
            end
            tests_run++;
            if (bus.MDU_HILOWr !== mon_e.hilowr || bus.MDU_RFWr !== mon_e.rfwr) begin
               tests_failed++;
               $display("FAIL write_flags op=%0d: got HILOWr=%0b RFWr=%0b, expected %0b %0b",
                        mon_e.op, bus.MDU_HILOWr, bus.MDU_RFWr, mon_e.hilowr, mon_e.rfwr);
            end
            tests_run++;
            if (bus.MDU_Busy !== 1'b0) begin
               tests_failed++;
               $display("FAIL busy_in_done op=%0d: got %0b, expected 0", mon_e.op, bus.MDU_Busy);
            end
            tests_run++;
            if (mon_e.rfwr) begin
               if (bus.MDU_MulRes !== mon_e.mulres) begin
                  tests_failed++;
                  $display("FAIL mulres op=%0d: got %08h, expected %08h", mon_e.op, bus.MDU_MulRes, mon_e.mulres);
               end
            end else if (bus.MDU_HI !== mon_e.hi || bus.MDU_LO !== mon_e.lo) begin
               tests_failed++;
               $display("FAIL hilo op=%0d: got HI=%08h LO=%08h, expected HI=%08h LO=%08h",
                        mon_e.op, bus.MDU_HI, bus.MDU_LO, mon_e.hi, mon_e.lo);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one op in the current cycle; Valid stays high for hold extra cycles.
   task automatic issue(input logic [6:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] hi, input logic [31:0] lo, input int hold);
      exp_t e;
      e = model(op, rs, rt, hi, lo);
      e.due = cyc + (is_div_op(op) ? DIV_LAT : TB_MUL_LAT);
      sb_q.push_back(e);
      bus.EXE_Valid  = 1'b1;
      bus.EXE_ALUOp  = op;
      bus.EXE_RsData = rs;
      bus.EXE_RtData = rt;
      bus.HI_Cur     = hi;
      bus.LO_Cur     = lo;
      #3;
      tests_run++;
      if (bus.MDU_Busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_busy op=%0d: got %0b, expected 1", op, bus.MDU_Busy);
      end
      repeat (hold) tick();
      tick();
      bus.EXE_Valid = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n = 0;
      while (sb_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain_timeout: %0d ops outstanding after %0d cycles, expected 0", sb_q.size(), n);
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.EXE_Valid = 1'b0; bus.EXE_ALUOp = OP_NOP; bus.Flush = 1'b0;
      bus.EXE_RsData = '0; bus.EXE_RtData = '0; bus.HI_Cur = '0; bus.LO_Cur = '0;
      repeat (2) @(posedge clk);
      #3;
      tests_run++;
      if ({bus.MDU_Busy, bus.MDU_Done, bus.MDU_HILOWr, bus.MDU_RFWr} !== 4'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %04b, expected 0000",
                  {bus.MDU_Busy, bus.MDU_Done, bus.MDU_HILOWr, bus.MDU_RFWr});
      end
      tests_run++;
      if ({bus.MDU_HI, bus.MDU_LO, bus.MDU_MulRes} !== 96'b0) begin
         tests_failed++;
         $display("FAIL reset_data: got HI=%08h LO=%08h MulRes=%08h, expected zeros",
                  bus.MDU_HI, bus.MDU_LO, bus.MDU_MulRes);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_mult();
      issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 0);
      #3;
      tests_run++;
      if (bus.MDU_Busy !== 1'b1 || bus.MDU_Done !== 1'b0) begin
         tests_failed++;
         $display("FAIL mult_t1: got Busy=%0b Done=%0b, expected 1 0", bus.MDU_Busy, bus.MDU_Done);
      end
      tick();
      #3;
      tests_run++;
      if (bus.MDU_Done !== 1'b1 || bus.MDU_HI !== 32'hFFFF_FFFF || bus.MDU_LO !== 32'hFFFF_FFFE) begin
         tests_failed++;
         $display("FAIL mult_t2: got Done=%0b HI=%08h LO=%08h, expected 1 FFFFFFFF FFFFFFFE",
                  bus.MDU_Done, bus.MDU_HI, bus.MDU_LO);
      end
      wait_drain(5);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
      wait_drain(5);
   endtask

   task automatic test_div();
      issue(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 0);
      repeat (31) tick();
      #3;
      tests_run++;
      if (bus.MDU_Busy !== 1'b1 || bus.MDU_Done !== 1'b0) begin
         tests_failed++;
         $display("FAIL divu_t32: got Busy=%0b Done=%0b, expected 1 0", bus.MDU_Busy, bus.MDU_Done);
      end
      wait_drain(40);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 0);
      wait_drain(40);
      issue(OP_DIV, 32'd1000, 32'hFFFF_FFFD, 32'h0, 32'h0, 0);
      wait_drain(40);
   endtask

   task automatic test_div_boundary();
      issue(OP_DIVU, 32'd5, 32'd0, 32'h0, 32'h0, 0);
      wait_drain(40);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'h0, 32'h0, 0);
      wait_drain(40);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
      wait_drain(40);
   endtask

   task automatic test_madd_msub();
      issue(OP_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 0);
      wait_drain(5);
      issue(OP_MSUB, 32'd1, 32'd1, 32'h0, 32'h0, 0);
      wait_drain(5);
      issue(OP_MADD, 32'hFFFF_FFFD, 32'd7, 32'h0000_0001, 32'h0000_0010, 0);
      wait_drain(5);
      issue(OP_MSUBU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'h0, 0);
      wait_drain(5);
   endtask

   task automatic test_mul();
      issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 0);
      #3;
      tick();
      #3;
      tests_run++;
      if (bus.MDU_RFWr !== 1'b1 || bus.MDU_HILOWr !== 1'b0 || bus.MDU_MulRes !== 32'h0) begin
         tests_failed++;
         $display("FAIL mul_t2: got RFWr=%0b HILOWr=%0b MulRes=%08h, expected 1 0 00000000",
                  bus.MDU_RFWr, bus.MDU_HILOWr, bus.MDU_MulRes);
      end
      wait_drain(5);
      issue(OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0, 0);
      wait_drain(5);
   endtask

   task automatic test_flush();
      int dc0;
      issue(OP_DIV, 32'd12345, 32'd17, 32'h0, 32'h0, 0);
      repeat (9) tick();
      bus.Flush = 1'b1;
      void'(sb_q.pop_back());
      dc0 = done_count;
      tick();
      bus.Flush = 1'b0;
      tests_run++;
      if (bus.MDU_Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_idle: got Busy=%0b, expected 0", bus.MDU_Busy);
      end
      issue(OP_MULT, 32'd6, 32'hFFFF_FFF9, 32'h0, 32'h0, 0);
      wait_drain(40);
      repeat (30) tick();
      tests_run++;
      if (done_count !== dc0 + 1) begin
         tests_failed++;
         $display("FAIL flush_no_done: got %0d Done pulses, expected %0d", done_count - dc0, 1);
      end
   endtask

   task automatic test_back_to_back();
      int dc0;
      dc0 = done_count;
      issue(OP_MULT, 32'd3, 32'd4, 32'h0, 32'h0, 2);
      issue(OP_DIVU, 32'hDEAD_BEEF, 32'd1000, 32'h0, 32'h0, 0);
      wait_drain(45);
      for (int i = 0; i < 6; i++) begin
         logic [6:0] op;
         case ($urandom_range(0, 4))
            0:       op = OP_MADD;
            1:       op = OP_MSUBU;
            2:       op = OP_DIV;
            3:       op = OP_MUL;
            default: op = OP_MULTU;
         endcase
         issue(op, $urandom, $urandom, $urandom, $urandom, 0);
         wait_drain(40);
      end
      tests_run++;
      if (done_count !== dc0 + 8) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d Done pulses, expected %0d", done_count - dc0, 8);
      end
   endtask

   task automatic test_ignored();
      int dc0;
      dc0 = done_count;
      bus.EXE_Valid = 1'b1;
      bus.EXE_ALUOp = OP_ADD;
      #3;
      tests_run++;
      if (bus.MDU_Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL ignored_add: got Busy=%0b, expected 0", bus.MDU_Busy);
      end
      tick();
      bus.EXE_ALUOp = OP_MFHI;
      #3;
      tests_run++;
      if (bus.MDU_Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL ignored_mfhi: got Busy=%0b, expected 0", bus.MDU_Busy);
      end
      tick();
      bus.EXE_Valid = 1'b0;
      repeat (5) tick();
      tests_run++;
      if (done_count !== dc0) begin
         tests_failed++;
         $display("FAIL ignored_done: got %0d Done pulses, expected 0", done_count - dc0);
      end
   endtask

   task automatic test_async_reset();
      int dc0;
      issue(OP_DIVU, 32'd1000, 32'd3, 32'h0, 32'h0, 0);
      repeat (10) tick();
      #2;
      rst = 1'b1;
      #1;
      sb_q.delete();
      dc0 = done_count;
      tests_run++;
      if ({bus.MDU_Busy, bus.MDU_Done, bus.MDU_HILOWr, bus.MDU_RFWr} !== 4'b0 ||
          {bus.MDU_HI, bus.MDU_LO, bus.MDU_MulRes} !== 96'b0) begin
         tests_failed++;
         $display("FAIL async_reset: got Busy=%0b Done=%0b HI=%08h LO=%08h, expected all zero",
                  bus.MDU_Busy, bus.MDU_Done, bus.MDU_HI, bus.MDU_LO);
      end
      tick();
      rst = 1'b0;
      repeat (40) tick();
      tests_run++;
      if (done_count !== dc0 || bus.MDU_Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset_after: got %0d Done pulses Busy=%0b, expected 0 0",
                  done_count - dc0, bus.MDU_Busy);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_boundary();
      test_madd_msub();
      test_mul();
      test_flush();
      test_back_to_back();
      test_ignored();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller in the EXE stage; owns the iterative HI/LO-producing datapath.
- Accepts one MDU instruction (InstrType op code) from EXE and stalls the pipeline while busy.
- Produces the HI/LO write (RegsWrType.HILOWr path), or the GPR result for OP_MUL.
- Aborts cleanly on a pipeline flush from exception handling.

Parameters:
- MUL_LAT, 2, cycles from start to Done for multiply-class ops; legal range 1..4.
- DIV_ITER, 32, radix-2 divider iterations; fixed at 32, not to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- EXE_Valid  in  1  instruction in EXE is valid
- EXE_ALUOp  in  7  InstrType op code
- EXE_RsData  in  32  rs operand
- EXE_RtData  in  32  rt operand
- HI_Cur  in  32  current architectural HI, forwarded
- LO_Cur  in  32  current architectural LO, forwarded
- Flush  in  1  kill the in-flight operation
- MDU_Busy  out  1  stall request to the pipeline
- MDU_Done  out  1  one-cycle result-valid pulse
- MDU_HILOWr  out  1  write HI and LO, qualified by Done
- MDU_HI  out  32  HI result
- MDU_LO  out  32  LO result
- MDU_RFWr  out  1  GPR write for OP_MUL, qualified by Done
- MDU_MulRes  out  32  low 32 bits of the product for OP_MUL

Behaviour:
- Accepted ops: MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU, DIV, DIVU. All other op codes are ignored.
- start = EXE_Valid & accepted op & state==IDLE & !Flush.
- At start: latch rs, rt, HI_Cur, LO_Cur and the op code.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on a multiply-class start; -> DIV on a divide start.
  - MUL -> DONE after MUL_LAT-1 cycles in MUL; if MUL_LAT==1, go IDLE -> DONE directly.
  - DIV -> DONE after 32 cycles in DIV.
  - DONE -> IDLE unconditionally.
  - Flush in any state -> IDLE next cycle. No Done pulse and no writes for the killed op. Flush has priority over start.
- Timing (start in cycle T):
  - Multiply: Done high in cycle T+MUL_LAT.
  - Divide: Done high in cycle T+33.
- MDU_Busy = start | (state==MUL) | (state==DIV). Busy is low in DONE so EXE advances in the same cycle it sees Done.
- Done = (state==DONE).
  - MDU_HILOWr = Done & op≠MUL.
  - MDU_RFWr = Done & op==MUL.
- Multiply arithmetic:
  - Signed ops (MULT, MUL, MADD, MSUB) sign-extend to 64 bits; unsigned ops zero-extend.
  - MADD/MADDU: {HI,LO} = {HI_Cur,LO_Cur} + product, mod 2^64.
  - MSUB/MSUBU: {HI,LO} = {HI_Cur,LO_Cur} - product, mod 2^64.
  - MUL: MDU_MulRes = product[31:0]; MDU_HI and MDU_LO are don't-care.
- Divide arithmetic:
  - Restoring radix-2 division on absolute values.
  - Signed fix-up after iteration: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero: still takes 33 cycles. DIVU gives LO=0xFFFFFFFF, HI=rs. DIV gives the same raw unsigned result on |rs|, then sign fix-up.
- Output hold: outputs keep their last value outside DONE. Consumers qualify with Done.
- Reset: state=IDLE; MDU_Busy, MDU_Done, MDU_HILOWr, MDU_RFWr = 0; MDU_HI, MDU_LO, MDU_MulRes = 0; divider counter = 0.
- Reset asserted mid-operation aborts immediately with no write.
- EXE_Valid while Busy is ignored; the pipeline is stalled and the same instruction stays in EXE.
- Back-to-back: a new start is legal in the cycle after DONE, not in DONE itself. This avoids re-accepting the stalled instruction, because EXE advances during DONE.

Decomposition:
- Shared package/header, next to CPU_Defines:
  - MDUStateType enum {IDLE, MUL, DIV, DONE}.
  - Localparams MDU_DIV_ITER=32 and MDU_MUL_LAT_DEFAULT=2.
  - An is_mdu_op helper set, matching against InstrType.
- Sub-module div_radix2: 32-iteration restoring divider.
  - Start, operands and signedness in; quotient, remainder and done out.
  - Abort input driven by Flush.
- The multiply pipeline stays inline as MUL_LAT register stages.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 at T -> Busy in T..T+1; Done/HILOWr at T+2; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIVU rs=100, rt=7 -> Busy T..T+32; Done at T+33; LO=14, HI=2. DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MADDU with HI_Cur=0, LO_Cur=0xFFFFFFFF, rs=1, rt=1 -> HI=1, LO=0. MSUB with HI/LO=0, rs=1, rt=1 -> HI=LO=0xFFFFFFFF.
- MUL rs=0x00010000, rt=0x00010000 -> MDU_RFWr=1, HILOWr=0, MulRes=0 at T+2.
- DIV started at T, Flush at T+10 -> no Done or write; IDLE at T+11; a MULT issued at T+11 completes at T+13.
- DIVU rs=5, rt=0 -> Done at T+33, LO=0xFFFFFFFF, HI=5. Async rst pulse mid-DIV -> all outputs 0 immediately, no Done afterwards.
